// File: rtl/alu_responder.sv
// Buffered 8-bit ALU responder: requests are evaluated combinationally and queued
// with their flags in a small FIFO; results drain in order on a valid/ready channel.
module alu_responder #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  input  logic [3:0]       req_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic [3:0]       rsp_flags,
  output logic [15:0]      rsp_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = WIDTH + 4;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             cin;
  logic             v_flag;
  logic             c_flag;
  logic [EW-1:0]    entry_d;
  logic             unused_flags;

  assign unused_flags = ^req_flags[3:1];

  always_comb begin
    cin    = req_flags[0];
    sum    = '0;
    res    = '0;
    v_flag = 1'b0;
    c_flag = cin;
    case (req_op)
      3'b000:  sum = {1'b0, req_a} + {1'b0, req_b};
      3'b001:  sum = {1'b0, req_a} + {1'b0, req_b} + {{WIDTH{1'b0}}, cin};
      3'b010:  sum = {1'b0, req_a} - {1'b0, req_b};
      3'b011:  sum = {1'b0, req_a} - {1'b0, req_b} - {{WIDTH{1'b0}}, cin};
      default: sum = '0;
    endcase
    if (!req_op[2]) begin
      // top bit of the WIDTH+1 result is carry for add, borrow for subtract
      res    = sum[WIDTH-1:0];
      c_flag = sum[WIDTH];
      if (!req_op[1])
        v_flag = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (res[WIDTH-1] != req_a[WIDTH-1]);
      else
        v_flag = (req_a[WIDTH-1] != req_b[WIDTH-1]) && (res[WIDTH-1] != req_a[WIDTH-1]);
    end else begin
      case (req_op[1:0])
        2'b00:   res = req_a & req_b;
        2'b01:   res = req_a | req_b;
        2'b10:   res = req_a ^ req_b;
        default: res = req_b;
      endcase
    end
    entry_d = {res, v_flag, res[WIDTH-1], (res == '0), c_flag};
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   rsp_count_q, rsp_count_d;
  logic          push;
  logic          pop;

  assign req_ready = (cnt_q != FULL_CNT);
  assign rsp_valid = (cnt_q != '0);
  assign push      = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rsp_count_d = rsp_count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      rsp_count_d = rsp_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_count_q <= rsp_count_d;
      if (push) mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign rsp_z     = mem_q[rd_ptr_q][EW-1:4];
  assign rsp_flags = mem_q[rd_ptr_q][3:0];
  assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: fixed corner vectors, hand sequences for
// back-pressure and reset, and random traffic against an integer-arithmetic model.
module tb_alu_responder;

  localparam int DEPTH = 2;

  logic       clock;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [2:0] req_op;
  logic [3:0] req_flags;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_z;
  logic [3:0] rsp_flags;
  logic [15:0] rsp_count;

  alu_responder #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_op   (req_op),
    .req_flags(req_flags),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_z    (rsp_z),
    .rsp_flags(rsp_flags),
    .rsp_count(rsp_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks;
  int failures;
  int pops;
  logic [11:0] q[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] z;
    logic [3:0] fl;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, flags {V,N,Z,C}
  function automatic logic [11:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
    int ua, ub, uc, sa, sb, r, sr;
    logic v, c;
    logic [7:0] z;
    ua = a; ub = b; uc = cin;
    sa = $signed(a); sb = $signed(b);
    v = 1'b0; c = cin; r = 0; sr = 0;
    case (op)
      3'd0: begin r = ua + ub;      sr = sa + sb;      c = (r > 255);       end
      3'd1: begin r = ua + ub + uc; sr = sa + sb + uc; c = (r > 255);       end
      3'd2: begin r = ua - ub;      sr = sa - sb;      c = (ua < ub);       end
      3'd3: begin r = ua - ub - uc; sr = sa - sb - uc; c = (ua < ub + uc);  end
      3'd4: r = ua & ub;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: r = ub;
    endcase
    if (op < 3'd4) v = (sr > 127) || (sr < -128);
    z = r[7:0];
    return {z, v, z[7], (z == 8'd0), c};
  endfunction

  // One clock: drive at negedge, check state-derived outputs, advance model, return at next negedge
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [3:0] fl, input logic rdy,
                      output logic acc);
    logic will_pop;
    req_valid = v; req_a = a; req_b = b; req_op = op; req_flags = fl; rsp_ready = rdy;
    #1;
    check("rsp_valid", 16'(rsp_valid), 16'(q.size() != 0));
    check("req_ready", 16'(req_ready), 16'(q.size() < DEPTH));
    check("rsp_count", rsp_count, 16'(pops));
    if (q.size() != 0) check("rsp_head", 16'({rsp_z, rsp_flags}), 16'(q[0]));
    acc = v && (q.size() < DEPTH);
    will_pop = rdy && (q.size() != 0);
    if (will_pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (acc) q.push_back(ref_alu(op, a, b, fl[0]));
    @(posedge clock);
    @(negedge clock);
  endtask

  logic acc;

  initial begin
    checks = 0; failures = 0; pops = 0;
    vecs[0]  = '{3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011};
    vecs[1]  = '{3'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0101};
    vecs[2]  = '{3'd3, 8'h80, 8'h00, 1'b1, 8'h7F, 4'b1000};
    vecs[3]  = '{3'd4, 8'hF0, 8'h0F, 1'b1, 8'h00, 4'b0011};
    vecs[4]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011};
    vecs[5]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100};
    vecs[6]  = '{3'd5, 8'hA0, 8'h05, 1'b0, 8'hA5, 4'b0100};
    vecs[7]  = '{3'd6, 8'hFF, 8'hFF, 1'b1, 8'h00, 4'b0011};
    vecs[8]  = '{3'd7, 8'h12, 8'h80, 1'b0, 8'h80, 4'b0100};
    vecs[9]  = '{3'd2, 8'h05, 8'h03, 1'b0, 8'h02, 4'b0000};
    vecs[10] = '{3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1011};
    vecs[11] = '{3'd3, 8'h03, 8'h03, 1'b1, 8'hFF, 4'b0101};
    vecs[12] = '{3'd1, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b1100};

    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    req_flags = '0; rsp_ready = 1'b0;
    #2;
    check("rst_valid", 16'(rsp_valid), 16'd0);
    check("rst_ready", 16'(req_ready), 16'd1);
    check("rst_count", rsp_count, 16'd0);
    check("rst_z", 16'(rsp_z), 16'd0);
    check("rst_flags", 16'(rsp_flags), 16'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Corner vectors; upper flag bits set to show only C is consumed
    for (int i = 0; i < NV; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, {3'b101, vecs[i].cin}, 1'b1, acc);
      req_valid = 1'b0;
      #1;
      check($sformatf("tbl%0d_valid", i), 16'(rsp_valid), 16'd1);
      check($sformatf("tbl%0d_z", i), 16'(rsp_z), 16'(vecs[i].z));
      check($sformatf("tbl%0d_flags", i), 16'(rsp_flags), 16'(vecs[i].fl));
      step(1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b1, acc);
    end

    // ADD sweep, streaming
    for (int a = 0; a < 256; a++) step(1'b1, 8'(a), 8'h01, 3'd0, 4'd0, 1'b1, acc);
    repeat (2) step(1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b1, acc);

    // Back-pressure and full-with-pop
    step(1'b1, 8'h11, 8'h22, 3'd0, 4'd0, 1'b0, acc);
    step(1'b1, 8'h33, 8'h44, 3'd2, 4'd0, 1'b0, acc);
    check("bp_full_ready", 16'(req_ready), 16'd0);
    check("bp_head1", 16'(rsp_z), 16'h33);
    step(1'b1, 8'h55, 8'h66, 3'd6, 4'd0, 1'b0, acc);
    check("bp_still_full", 16'(req_ready), 16'd0);
    step(1'b1, 8'h55, 8'h66, 3'd6, 4'd0, 1'b1, acc);
    check("bp_ready_after_pop", 16'(req_ready), 16'd1);
    check("bp_head2", 16'(rsp_z), 16'hEF);
    step(1'b1, 8'h55, 8'h66, 3'd6, 4'd0, 1'b1, acc);
    check("bp_head3", 16'(rsp_z), 16'h33);
    check("bp_occ1_ready", 16'(req_ready), 16'd1);
    step(1'b1, 8'h01, 8'h02, 3'd5, 4'd0, 1'b1, acc);
    check("occ1_valid", 16'(rsp_valid), 16'd1);
    check("occ1_ready", 16'(req_ready), 16'd1);
    check("occ1_head", 16'(rsp_z), 16'h03);
    step(1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b1, acc);
    check("occ1_drained", 16'(rsp_valid), 16'd0);

    // Reset with two results buffered
    step(1'b1, 8'hAA, 8'h01, 3'd0, 4'd0, 1'b0, acc);
    step(1'b1, 8'hBB, 8'h01, 3'd0, 4'd0, 1'b0, acc);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(rsp_valid), 16'd0);
    check("mid_rst_ready", 16'(req_ready), 16'd1);
    check("mid_rst_count", rsp_count, 16'd0);
    check("mid_rst_z", 16'(rsp_z), 16'd0);
    q.delete();
    pops = 0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    step(1'b1, 8'h40, 8'h02, 3'd2, 4'd0, 1'b0, acc);
    check("post_rst_z", 16'(rsp_z), 16'h3E);
    check("post_rst_flags", 16'(rsp_flags), 16'd0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b1, acc);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
           4'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    repeat (3) step(1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b1, acc);

    // Counter wrap after a fresh reset
    @(negedge clock);
    #2 reset_n = 1'b0;
    q.delete();
    pops = 0;
    #2 reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 70000 && pops < 65537; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 4'($urandom), 1'b1, acc);
    check("wrap_count", rsp_count, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_responder.md
# alu_responder

Handshaked, buffered ALU execution unit: the responder side of the ALU stimulus flow. An initiator (testbench or sequencer) presents operand/opcode requests on a valid/ready channel. The block computes each result with the team's 8-bit ALU operation set and returns results in order on a second valid/ready channel through a small output FIFO, so back-pressure on the result side never corrupts or drops requests.

## Interface
- DEPTH, 2, result FIFO entries (power of two, ≥2)
- WIDTH, 8, operand/result width
- clock  in  1  system clock, rising-edge active
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_op  in  3  operation code
- req_flags  in  4  flags_in {V,N,Z,C}; only C (bit 0) is consumed
- rsp_valid  out  1  result available at FIFO head
- rsp_ready  in  1  consumer takes the result when rsp_valid && rsp_ready at a rising edge
- rsp_z  out  WIDTH  result
- rsp_flags  out  4  flags_out {V,N,Z,C}
- rsp_count  out  16  number of results consumed; wraps 0xFFFF→0x0000

## Operation
- Opcodes: 000 ADD A+B; 001 ADC A+B+Cin; 010 SUB A−B; 011 SBB A−B−Cin; 100 AND; 101 OR; 110 XOR; 111 PASSB (Z=B).
- Arithmetic is performed at WIDTH+1 bits. ADD/ADC: C = carry out of bit WIDTH−1. SUB/SBB: C = borrow (1 when the unsigned minuend is smaller than the subtrahend plus Cin).
- V = two's-complement overflow for ops 000–011. V = 0 for ops 100–111.
- For all ops: N = Z[WIDTH−1]; Zflag = (Z == 0). For ops 100–111, C passes req_flags[0] through unchanged.
- The result and flags are computed combinationally from the request. They are written into the FIFO on the accepting edge. The FIFO stores {z, flags}.
- req_ready = !full. There is no pass-through when full, even if rsp_ready is high.
- rsp_valid = !empty. rsp_z/rsp_flags always show the FIFO head. Their value is don't-care when empty.
- Push-only: occupancy +1. Pop-only: occupancy −1. Simultaneous push and pop: occupancy unchanged, and read/write pointers both advance, wrapping modulo DEPTH.
- Results are returned strictly in acceptance order.
- rsp_count increments on every pop.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): FIFO empty, pointers 0, rsp_valid=0, req_ready=1, rsp_count=0, rsp_z=0, rsp_flags=0.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N when the FIFO was empty. Results behind older entries appear once those entries are popped.
- Throughput: one request and one response per cycle, sustained while the FIFO is neither full nor empty, or while push and pop coincide.
- Full: req_ready drops after the edge that fills the FIFO. It rises after the next pop.
- Empty with rsp_ready=1: no pop, and rsp_count does not change.
- Reset asserted mid-stream: all buffered results are discarded immediately, and outputs take their reset values asynchronously.
- All outputs are registered-state derived. No combinational path from req_* to rsp_*, and none from rsp_ready to req_ready.

## Test plan
- ADD sweep: op=000, flags=0, B=0x01, A=0x00..0xFF, rsp_ready=1. Each rsp_z = A+1 (mod 256), one cycle after acceptance. A=0xFF gives z=0x00, flags C=1, Z=1. A=0x7F gives z=0x80, V=1, N=1.
- Arithmetic corners with Cin: ADC 0xFF+0x00+Cin=1 → 0x00, C=1, Z=1. SUB 0x00−0x01 → 0xFF, C=1, N=1. SBB 0x80−0x00−Cin=1 → 0x7F, V=1. AND 0xF0&0x0F with Cin=1 → 0x00, Z=1, C=1, V=0.
- Back-pressure: rsp_ready=0, issue 3 requests. Two are accepted and req_ready is 0 from the second edge. Raise rsp_ready: results come out in order and the third request is accepted the cycle after the first pop.
- Full with simultaneous events: FIFO full, req_valid=1, rsp_ready=1. Only the pop occurs at that edge; the push follows next cycle. With the FIFO at occupancy 1, push and pop together keep occupancy at 1 and keep order.
- Reset mid-operation: 2 entries buffered, pull reset_n low between edges. rsp_valid=0, req_ready=1 and rsp_count=0 immediately. The first request after release returns correctly.
- Counter wrap: drive 65537 pops. rsp_count reads 0x0001.
